// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard and stall controller for the five-stage MIPS
//            core. Detects load-use hazards, issues the ID/EX bubble,
//            sequences the multi-cycle mult/div unit and holds HI/LO readers
//            until the result is written, flushes IF/ID on taken branches and
//            keeps a saturating stall-cycle counter.
// Ports    : clock, resetn          - clock, async active-low reset
//            ifid_rs/ifid_rt        - source registers of the ID instruction
//            idex_memread/idex_rt   - load in EX and its destination
//            id_muldiv/id_is_div    - mult/div in ID and divide qualifier
//            id_uses_hilo           - mfhi/mflo/mthi/mtlo in ID
//            branch_taken           - branch/jump resolved taken in EX
//            pc_write, ifid_write   - PC and IF/ID load enables
//            ifid_flush, idex_bubble- IF/ID kill and ID/EX nop insertion
//            muldiv_start/busy/done - mult/div unit sequencing
//            stall_count            - saturating count of pc_write=0 cycles
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic        id_muldiv,
    input  logic        id_is_div,
    input  logic        id_uses_hilo,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        muldiv_start,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic [15:0] stall_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter is loaded with N-1 so that done coincides with the Nth busy cycle.
    localparam logic [5:0] c_MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] c_DIV_LOAD  = 6'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] stall_q, stall_d;

    logic        w_load_use;
    logic        w_hilo_stall;

    always_comb begin
        w_load_use   = idex_memread && (idex_rt != 5'd0) &&
                       ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
        w_hilo_stall = (state_q == BUSY) && (id_uses_hilo || id_muldiv);

        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        muldiv_start = 1'b0;
        muldiv_busy  = 1'b0;
        muldiv_done  = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        // A taken branch kills the ID instruction, so its stalls are moot.
        if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_hilo_stall || w_load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end

        muldiv_start = (state_q == IDLE) && id_muldiv && !w_load_use && !branch_taken;

        case (state_q)
            IDLE: begin
                if (muldiv_start) begin
                    state_d = BUSY;
                    cnt_d   = id_is_div ? c_DIV_LOAD : c_MULT_LOAD;
                end
            end
            BUSY: begin
                // Branches never abort: the issuing mult/div is older.
                muldiv_busy = 1'b1;
                if (cnt_q != 6'd0) begin
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    muldiv_done = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_d = stall_q;
        if (!pc_write && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end

        // Reset forces a safe, stalled pipeline regardless of inputs.
        if (!resetn) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b0;
            idex_bubble  = 1'b1;
            muldiv_start = 1'b0;
            muldiv_busy  = 1'b0;
            muldiv_done  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. Expected output vectors are
//            queued as each cycle's stimulus is driven and popped when the
//            outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    // Output vector: {pc_write, ifid_write, ifid_flush, idex_bubble,
    //                 muldiv_start, muldiv_busy, muldiv_done}
    localparam logic [6:0] V_RUN   = 7'b1100000;
    localparam logic [6:0] V_START = 7'b1100100;
    localparam logic [6:0] V_STALL = 7'b0001000;
    localparam logic [6:0] V_HOLD  = 7'b0001010;
    localparam logic [6:0] V_HOLDD = 7'b0001011;
    localparam logic [6:0] V_BUSY  = 7'b1100010;
    localparam logic [6:0] V_BUSYD = 7'b1100011;
    localparam logic [6:0] V_BR    = 7'b1111000;
    localparam logic [6:0] V_BRBSY = 7'b1111010;
    localparam logic [6:0] V_RST   = 7'b0001000;

    typedef struct packed {
        logic [6:0]  vec;
        logic [15:0] cnt;
    } exp_t;

    logic        clock;
    logic        resetn;
    logic [4:0]  ifid_rs, ifid_rt, idex_rt;
    logic        idex_memread, id_muldiv, id_is_div, id_uses_hilo, branch_taken;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic        muldiv_start, muldiv_busy, muldiv_done;
    logic [15:0] stall_count;

    exp_t        sb[$];
    logic [15:0] exp_stall;
    int          n_chk;
    int          n_fail;

    hazard_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .idex_memread(idex_memread),
        .idex_rt     (idex_rt),
        .id_muldiv   (id_muldiv),
        .id_is_div   (id_is_div),
        .id_uses_hilo(id_uses_hilo),
        .branch_taken(branch_taken),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .muldiv_start(muldiv_start),
        .muldiv_busy (muldiv_busy),
        .muldiv_done (muldiv_done),
        .stall_count (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] outv();
        return {pc_write, ifid_write, ifid_flush, idex_bubble,
                muldiv_start, muldiv_busy, muldiv_done};
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue what the
    // outputs must be during that cycle. A cycle with pc_write=0 adds one to
    // the expected counter seen from the next cycle on.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic mr, input logic [4:0] xrt,
                         input logic md, input logic dv, input logic hl,
                         input logic br, input logic [6:0] v);
        exp_t e;
        @(negedge clock);
        ifid_rs      = rs;
        ifid_rt      = rt;
        idex_memread = mr;
        idex_rt      = xrt;
        id_muldiv    = md;
        id_is_div    = dv;
        id_uses_hilo = hl;
        branch_taken = br;
        e.vec = v;
        e.cnt = exp_stall;
        sb.push_back(e);
        if (!v[6] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    endtask

    task automatic test_reset();
        exp_t e;
        resetn = 1'b0;
        ifid_rs = 5'd3; ifid_rt = 5'd3; idex_memread = 1'b1; idex_rt = 5'd3;
        id_muldiv = 1'b1; id_is_div = 1'b0; id_uses_hilo = 1'b1; branch_taken = 1'b1;
        exp_stall = 16'd0;
        e.vec = V_RST; e.cnt = 16'd0;
        sb.push_back(e);
        repeat (3) @(posedge clock);
        #1;
        e = sb.pop_front();
        n_chk++;
        if ({outv(), stall_count} !== e) begin
            n_fail++;
            $display("FAIL reset: got vec=%b cnt=%0d, want vec=%b cnt=%0d",
                     outv(), stall_count, e.vec, e.cnt);
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: drive(5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, V_STALL);
                1: drive(5'd5, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
                2: drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
                3: drive(5'd2, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, V_STALL);
                4: drive(5'd2, 5'd7, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
                default: drive(5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
            endcase
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({outv(), stall_count} !== e) begin
                n_fail++;
                $display("FAIL load_use c%0d: got vec=%b cnt=%0d, want vec=%b cnt=%0d",
                         c, outv(), stall_count, e.vec, e.cnt);
            end
        end
    endtask

    task automatic test_mult_mfhi();
        exp_t e;
        logic [15:0] base;
        base = exp_stall;
        for (int c = 0; c <= MULT_N + 1; c++) begin
            if (c == 0)
                drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, V_START);
            else if (c < MULT_N)
                drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLD);
            else if (c == MULT_N)
                drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLDD);
            else
                drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_RUN);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({outv(), stall_count} !== e) begin
                n_fail++;
                $display("FAIL mult_mfhi c%0d: got vec=%b cnt=%0d, want vec=%b cnt=%0d",
                         c, outv(), stall_count, e.vec, e.cnt);
            end
        end
        n_chk++;
        if (stall_count - base !== 16'd4) begin
            n_fail++;
            $display("FAIL mult_mfhi_stalls: got %0d, want 4", stall_count - base);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int c = 0; c <= 2 * DIV_N + 2; c++) begin
            if (c == 0 || c == DIV_N + 1)
                drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, V_START);
            else if (c < DIV_N)
                drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, V_HOLD);
            else if (c == DIV_N)
                drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, V_HOLDD);
            else if (c < 2 * DIV_N + 1)
                drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_BUSY);
            else if (c == 2 * DIV_N + 1)
                drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_BUSYD);
            else
                drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({outv(), stall_count} !== e) begin
                n_fail++;
                $display("FAIL back_to_back c%0d: got vec=%b cnt=%0d, want vec=%b cnt=%0d",
                         c, outv(), stall_count, e.vec, e.cnt);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        for (int c = 0; c < 9; c++) begin
            case (c)
                // taken branch beats a load-use hazard
                0: drive(5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, V_BR);
                // taken branch suppresses a mult issue in IDLE
                1: drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, V_BR);
                2: drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_RUN);
                // branch during BUSY does not abort the multiply
                3: drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, V_START);
                4: drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, V_BRBSY);
                // load-use plus hilo stall together: one stall cycle
                5: drive(5'd6, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLD);
                6: drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_BUSY);
                7: drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_BUSYD);
                default: drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
            endcase
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({outv(), stall_count} !== e) begin
                n_fail++;
                $display("FAIL branch c%0d: got vec=%b cnt=%0d, want vec=%b cnt=%0d",
                         c, outv(), stall_count, e.vec, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        exp_t e;
        for (int c = 0; c < 10; c++) begin
            if (c == 0)
                drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, V_START);
            else
                drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_BUSY);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({outv(), stall_count} !== e) begin
                n_fail++;
                $display("FAIL mid_div_pre c%0d: got vec=%b cnt=%0d, want vec=%b cnt=%0d",
                         c, outv(), stall_count, e.vec, e.cnt);
            end
        end
        // busy cycle 10: assert reset asynchronously
        @(negedge clock);
        resetn = 1'b0;
        exp_stall = 16'd0;
        e.vec = V_RST; e.cnt = 16'd0;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        n_chk++;
        if ({outv(), stall_count} !== e) begin
            n_fail++;
            $display("FAIL mid_div_reset: got vec=%b cnt=%0d, want vec=%b cnt=%0d",
                     outv(), stall_count, e.vec, e.cnt);
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int c = 0; c < DIV_N + 4; c++) begin
            drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({outv(), stall_count} !== e) begin
                n_fail++;
                $display("FAIL mid_div_post c%0d: got vec=%b cnt=%0d, want vec=%b cnt=%0d",
                         c, outv(), stall_count, e.vec, e.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        int   ph;
        logic [6:0] v;
        // Repeated divides with a div permanently waiting in ID: every
        // (DIV_N+1)-cycle period has DIV_N stall cycles.
        for (int c = 0; c < 68000; c++) begin
            ph = c % (DIV_N + 1);
            if (ph == 0)          v = V_START;
            else if (ph < DIV_N)  v = V_HOLD;
            else                  v = V_HOLDD;
            drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, v);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({outv(), stall_count} !== e) begin
                n_fail++;
                $display("FAIL saturation c%0d: got vec=%b cnt=%0d, want vec=%b cnt=%0d",
                         c, outv(), stall_count, e.vec, e.cnt);
            end
        end
        n_chk++;
        if (stall_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturation_final: got %h, want ffff", stall_count);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_load_use();
        test_mult_mfhi();
        test_back_to_back();
        test_branch();
        test_reset_mid_div();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
